// File: rtl/uart_line_buffer.sv
// Line-edit buffer between uart_rx and uart_tx: collects a line with backspace
// editing and, on CR, replays it followed by CR, LF, one byte per tx handshake.
module uart_line_buffer #(
    parameter int unsigned DEPTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_rx_valid,
    input  logic [7:0]                   i_rx_byte,
    output logic                         o_tx_valid,
    output logic [7:0]                   o_tx_byte,
    input  logic                         i_tx_done,
    output logic [$clog2(DEPTH+1)-1:0]   o_line_len,
    output logic                         o_busy,
    output logic                         o_overflow,
    output logic                         o_drop
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);

    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_DEL = 8'h7F;

    typedef enum logic [2:0] {
        COLLECT, SEND_CH, WAIT_CH, SEND_CR, WAIT_CR, SEND_LF, WAIT_LF
    } state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] count_q, count_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic          ovf_q, ovf_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic [LW-1:0] line_len_q, line_len_d;
    logic          busy_q, busy_d;
    logic          drop_q, drop_d;
    logic          wr_en;
    logic [7:0]    mem_q [DEPTH];

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        len_d      = len_q;
        idx_d      = idx_q;
        ovf_d      = ovf_q;
        tx_valid_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        wr_en      = 1'b0;

        case (state_q)
            COLLECT: begin
                if (i_rx_valid) begin
                    case (i_rx_byte)
                        CH_CR: begin
                            len_d   = count_q;
                            idx_d   = '0;
                            state_d = (count_q != '0) ? SEND_CH : SEND_CR;
                        end
                        CH_BS, CH_DEL: begin
                            if (count_q != '0) count_d = count_q - LW'(1);
                        end
                        CH_LF: ;
                        default: begin
                            if (count_q < LW'(DEPTH)) begin
                                wr_en   = 1'b1;
                                count_d = count_q + LW'(1);
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            SEND_CH: begin
                tx_valid_d = 1'b1;
                tx_byte_d  = mem_q[IW'(idx_q)];
                state_d    = WAIT_CH;
            end
            WAIT_CH: begin
                if (i_tx_done) begin
                    idx_d   = idx_q + LW'(1);
                    state_d = (idx_q == len_q - LW'(1)) ? SEND_CR : SEND_CH;
                end
            end
            SEND_CR: begin
                tx_valid_d = 1'b1;
                tx_byte_d  = CH_CR;
                state_d    = WAIT_CR;
            end
            WAIT_CR: begin
                if (i_tx_done) state_d = SEND_LF;
            end
            SEND_LF: begin
                tx_valid_d = 1'b1;
                tx_byte_d  = CH_LF;
                state_d    = WAIT_LF;
            end
            WAIT_LF: begin
                if (i_tx_done) begin
                    state_d = COLLECT;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = COLLECT;
        endcase

        // Status outputs reflect the state being entered so they stay registered
        busy_d     = (state_d != COLLECT);
        line_len_d = (state_d == COLLECT) ? count_d : len_d;
        drop_d     = i_rx_valid && (state_q != COLLECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            count_q    <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            ovf_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_byte_q  <= '0;
            line_len_q <= '0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            ovf_q      <= ovf_d;
            tx_valid_q <= tx_valid_d;
            tx_byte_q  <= tx_byte_d;
            line_len_q <= line_len_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
        end
    end

    // Line storage needs no reset; contents past count are never read
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[IW'(count_q)] <= i_rx_byte;
    end

    assign o_tx_valid = tx_valid_q;
    assign o_tx_byte  = tx_byte_q;
    assign o_line_len = line_len_q;
    assign o_busy     = busy_q;
    assign o_overflow = ovf_q;
    assign o_drop     = drop_q;

endmodule

// File: tb/tb_uart_line_buffer.sv
// Self-checking bench for uart_line_buffer: random lines and directed edit,
// overflow, drop and reset scenarios against a queue-based line model.
module tb_uart_line_buffer;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_rx_valid = 1'b0;
    logic [7:0]    i_rx_byte = 8'h00;
    logic          i_tx_done = 1'b0;
    logic          o_tx_valid;
    logic [7:0]    o_tx_byte;
    logic [LW-1:0] o_line_len;
    logic          o_busy;
    logic          o_overflow;
    logic          o_drop;

    always #5 clk = ~clk;

    uart_line_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rx_valid (i_rx_valid),
        .i_rx_byte  (i_rx_byte),
        .o_tx_valid (o_tx_valid),
        .o_tx_byte  (o_tx_byte),
        .i_tx_done  (i_tx_done),
        .o_line_len (o_line_len),
        .o_busy     (o_busy),
        .o_overflow (o_overflow),
        .o_drop     (o_drop)
    );

    int checks = 0;
    int errors = 0;

    // Observed traffic, appended by the monitors and only read by tests
    logic [7:0]    tx_q[$];
    logic [LW-1:0] txlen_q[$];
    int drop_cnt = 0;
    int valid_cnt = 0;
    int done_cnt = 0;
    int spacing_err = 0;

    int resp_fixed = -1;

    always @(posedge clk) if (i_tx_done && rst_n) done_cnt++;

    always @(negedge clk) begin
        if (!rst_n) begin
            valid_cnt = done_cnt;
        end else begin
            if (o_tx_valid) begin
                if (valid_cnt != done_cnt) spacing_err++;
                valid_cnt++;
                tx_q.push_back(o_tx_byte);
                txlen_q.push_back(o_line_len);
            end
            if (o_drop) drop_cnt++;
        end
    end

    // uart_tx stand-in: pulses done 0..10 cycles after each start
    int resp_d;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && o_tx_valid) begin
                resp_d = (resp_fixed >= 0) ? resp_fixed : int'($urandom_range(0, 10));
                repeat (resp_d) @(negedge clk);
                i_tx_done = 1'b1;
                @(negedge clk);
                i_tx_done = 1'b0;
            end
        end
    end

    // Reference model: the line as a list of characters
    logic [7:0]    stim_q[$];
    logic [7:0]    exp_q[$];
    logic [LW-1:0] exp_len;
    logic          exp_ovf;

    function automatic void build_model();
        logic [7:0] line[$];
        exp_ovf = 1'b0;
        foreach (stim_q[i]) begin
            if (stim_q[i] == 8'h0D) break;
            else if (stim_q[i] == 8'h08 || stim_q[i] == 8'h7F) begin
                if (line.size() > 0) void'(line.pop_back());
            end else if (stim_q[i] == 8'h0A) begin
            end else if (line.size() < DEPTH) line.push_back(stim_q[i]);
            else exp_ovf = 1'b1;
        end
        exp_len = LW'(line.size());
        exp_q = line;
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_valid = 1'b1;
        i_rx_byte  = b;
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic play_stim();
        foreach (stim_q[i]) send_byte(stim_q[i]);
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        ok = 1'b1;
        @(negedge clk);
        while (o_busy) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin ok = 1'b0; break; end
        end
    endtask

    task automatic wait_tx_valid(output bit ok);
        int n = 0;
        ok = 1'b1;
        while (!o_tx_valid) begin
            @(negedge clk);
            n++;
            if (n > 200) begin ok = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", o_tx_valid); end
        checks++; if (o_tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got %h exp 00", o_tx_byte); end
        checks++; if (o_line_len !== '0) begin errors++; $display("FAIL reset_line_len got %0d exp 0", o_line_len); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", o_overflow); end
        checks++; if (o_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b exp 0", o_drop); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int base = tx_q.size();
        bit ok;
        stim_q = '{8'h41, 8'h42, 8'h0D};
        build_model();
        play_stim();
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got busy exp idle"); end
        checks++; if (tx_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL basic_count got %0d exp %0d", tx_q.size() - base, exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (base + i >= tx_q.size() || tx_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte%0d got %h exp %h", i, (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx, exp_q[i]); end
            checks++;
            if (base + i >= txlen_q.size() || txlen_q[base + i] !== LW'(2)) begin errors++; $display("FAIL basic_len%0d got %0d exp 2", i, (base + i < txlen_q.size()) ? txlen_q[base + i] : 'x); end
        end
        checks++; if (o_line_len !== '0 || o_busy !== 1'b0) begin errors++; $display("FAIL basic_after got len %0d busy %b exp 0 0", o_line_len, o_busy); end
    endtask

    task automatic test_backspace();
        int base;
        bit ok;
        send_byte(8'h08);
        checks++; if (o_line_len !== '0) begin errors++; $display("FAIL bs_empty got %0d exp 0", o_line_len); end
        base = tx_q.size();
        stim_q = '{8'h41, 8'h42, 8'h43, 8'h08, 8'h44, 8'h0D};
        build_model();
        play_stim();
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bs_timeout got busy exp idle"); end
        checks++; if (tx_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL bs_count got %0d exp %0d", tx_q.size() - base, exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (base + i >= tx_q.size() || tx_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL bs_byte%0d got %h exp %h", i, (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx, exp_q[i]); end
        end
    endtask

    task automatic test_bare_cr();
        int base = tx_q.size();
        bit ok;
        stim_q = '{8'h0D};
        build_model();
        play_stim();
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bare_timeout got busy exp idle"); end
        checks++; if (tx_q.size() - base !== 2) begin errors++; $display("FAIL bare_count got %0d exp 2", tx_q.size() - base); end
        foreach (exp_q[i]) begin
            checks++;
            if (base + i >= tx_q.size() || tx_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL bare_byte%0d got %h exp %h", i, (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx, exp_q[i]); end
        end
        send_byte(8'h5A);
        send_byte(8'h0A);
        checks++; if (o_line_len !== LW'(1)) begin errors++; $display("FAIL lf_ignored got %0d exp 1", o_line_len); end
        send_byte(8'h7F);
        checks++; if (o_line_len !== '0) begin errors++; $display("FAIL del_char got %0d exp 0", o_line_len); end
    endtask

    task automatic test_overflow();
        int base = tx_q.size();
        bit ok;
        stim_q.delete();
        for (int i = 0; i < DEPTH + 3; i++) stim_q.push_back(8'h61 + 8'(i % 26));
        stim_q.push_back(8'h0D);
        build_model();
        for (int i = 0; i < DEPTH; i++) send_byte(stim_q[i]);
        checks++; if (o_overflow !== 1'b0 || o_line_len !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_full got ovf %b len %0d exp 0 %0d", o_overflow, o_line_len, DEPTH); end
        send_byte(stim_q[DEPTH]);
        checks++; if (o_overflow !== 1'b1 || o_line_len !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_set got ovf %b len %0d exp 1 %0d", o_overflow, o_line_len, DEPTH); end
        for (int i = DEPTH + 1; i < stim_q.size(); i++) send_byte(stim_q[i]);
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout got busy exp idle"); end
        checks++; if (tx_q.size() - base !== DEPTH + 2) begin errors++; $display("FAIL ovf_count got %0d exp %0d", tx_q.size() - base, DEPTH + 2); end
        foreach (exp_q[i]) begin
            checks++;
            if (base + i >= tx_q.size() || tx_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte%0d got %h exp %h", i, (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx, exp_q[i]); end
        end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", o_overflow); end
    endtask

    task automatic test_drop();
        int base = tx_q.size();
        int drops0 = drop_cnt;
        bit ok;
        stim_q = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D};
        build_model();
        resp_fixed = 10;
        play_stim();
        wait_tx_valid(ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_start got idle exp tx_valid"); end
        @(negedge clk);
        i_rx_valid = 1'b1;
        i_rx_byte  = 8'h58;
        @(negedge clk);
        i_rx_valid = 1'b0;
        checks++; if (o_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b exp 1", o_drop); end
        @(negedge clk);
        checks++; if (o_drop !== 1'b0) begin errors++; $display("FAIL drop_end got %b exp 0", o_drop); end
        resp_fixed = -1;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_timeout got busy exp idle"); end
        checks++; if (drop_cnt - drops0 !== 1) begin errors++; $display("FAIL drop_count got %0d exp 1", drop_cnt - drops0); end
        checks++; if (tx_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL drop_txcount got %0d exp %0d", tx_q.size() - base, exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (base + i >= tx_q.size() || tx_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL drop_byte%0d got %h exp %h", i, (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx, exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int base;
        int n;
        int r;
        bit ok;
        for (int line = 0; line < 12; line++) begin
            base = tx_q.size();
            n = int'($urandom_range(0, DEPTH + 6));
            stim_q.delete();
            for (int i = 0; i < n; i++) begin
                r = int'($urandom_range(0, 11));
                if (r == 0) stim_q.push_back(8'h08);
                else if (r == 1) stim_q.push_back(8'h7F);
                else if (r == 2) stim_q.push_back(8'h0A);
                else stim_q.push_back(8'($urandom_range(32, 126)));
            end
            stim_q.push_back(8'h0D);
            build_model();
            for (int i = 0; i < n; i++) send_byte(stim_q[i]);
            checks++; if (o_line_len !== exp_len || o_overflow !== exp_ovf) begin errors++; $display("FAIL rnd%0d_pre got len %0d ovf %b exp %0d %b", line, o_line_len, o_overflow, exp_len, exp_ovf); end
            send_byte(8'h0D);
            wait_idle(ok);
            checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_timeout got busy exp idle", line); end
            checks++; if (tx_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL rnd%0d_count got %0d exp %0d", line, tx_q.size() - base, exp_q.size()); end
            foreach (exp_q[i]) begin
                checks++;
                if (base + i >= tx_q.size() || tx_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_byte%0d got %h exp %h", line, i, (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx, exp_q[i]); end
            end
        end
        checks++; if (spacing_err !== 0) begin errors++; $display("FAIL tx_spacing got %0d exp 0", spacing_err); end
    endtask

    task automatic test_reset_midline();
        int base;
        bit ok;
        resp_fixed = 10;
        send_byte(8'h4D);
        send_byte(8'h0D);
        wait_tx_valid(ok);
        @(negedge clk);
        wait_tx_valid(ok);
        checks++; if (!ok || o_tx_byte !== 8'h0D) begin errors++; $display("FAIL rstmid_cr got %h exp 0d", o_tx_byte); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({o_tx_valid, o_busy, o_overflow, o_drop} !== 4'b0 || o_tx_byte !== 8'h00 || o_line_len !== '0)
            begin errors++; $display("FAIL rstmid_outputs got v%b b%b o%b d%b byte %h len %0d exp all 0", o_tx_valid, o_busy, o_overflow, o_drop, o_tx_byte, o_line_len); end
        repeat (15) @(negedge clk);
        rst_n = 1'b1;
        resp_fixed = -1;
        base = tx_q.size();
        stim_q = '{8'h51, 8'h0D};
        build_model();
        play_stim();
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout got busy exp idle"); end
        checks++; if (tx_q.size() - base !== 3) begin errors++; $display("FAIL rstmid_count got %0d exp 3", tx_q.size() - base); end
        foreach (exp_q[i]) begin
            checks++;
            if (base + i >= tx_q.size() || tx_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_byte%0d got %h exp %h", i, (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx, exp_q[i]); end
        end
        checks++; if (spacing_err !== 0) begin errors++; $display("FAIL rstmid_spacing got %0d exp 0", spacing_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backspace();
        test_bare_cr();
        test_overflow();
        test_drop();
        test_random();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
